// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding,
// latency limit and the address range check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned LATENCY_MAX = 15;

  // In range when base <= addr < base + 4*2**aw (33-bit to catch addr < base).
  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned aw
  );
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return !off[32] && ((off[31:0] >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with byte write enables and registered read data.
// Ports: clk/rst, wr_en/rd_en/rd_clr, idx, be, wdata in; rdata out.
module dmem_bank #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] idx,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds its value until the next read or clear.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr) rdata_d = '0;
    else if (rd_en) rdata_d = mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: FSM, wait-state counter, request register.
// Ports: clk, rst, req, we, addr, sel, wdata, flush in; rdata, stall, err out.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        rq_we_q, rq_we_d;
  logic [31:0] rq_addr_q, rq_addr_d;
  logic [3:0]  rq_sel_q, rq_sel_d;
  logic [31:0] rq_wdata_q, rq_wdata_d;

  logic              commit;
  logic              c_we;
  logic [31:0]       c_addr;
  logic [3:0]        c_sel;
  logic [31:0]       c_wdata;
  logic              c_ok;
  logic [31:0]       c_off;
  logic [ADDR_W-1:0] c_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rq_we_d    = rq_we_q;
    rq_addr_d  = rq_addr_q;
    rq_sel_d   = rq_sel_q;
    rq_wdata_d = rq_wdata_q;
    commit     = 1'b0;
    c_we       = rq_we_q;
    c_addr     = rq_addr_q;
    c_sel      = rq_sel_q;
    c_wdata    = rq_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req && !flush) begin
          rq_we_d    = we;
          rq_addr_d  = addr;
          rq_sel_d   = sel;
          rq_wdata_d = wdata;
          cnt_d      = CNT_INIT;
          if (LATENCY == 1) begin
            // Single wait state: commit straight from the CPU inputs.
            commit  = 1'b1;
            c_we    = we;
            c_addr  = addr;
            c_sel   = sel;
            c_wdata = wdata;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            commit  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign c_ok  = addr_in_range(c_addr, BASE, ADDR_W);
  assign c_off = c_addr - BASE;
  assign c_idx = ADDR_W'(c_off >> 2);
  assign err_d = commit && !c_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rq_we_q    <= 1'b0;
      rq_addr_q  <= '0;
      rq_sel_q   <= '0;
      rq_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rq_we_q    <= rq_we_d;
      rq_addr_q  <= rq_addr_d;
      rq_sel_q   <= rq_sel_d;
      rq_wdata_q <= rq_wdata_d;
    end
  end

  // Out-of-range accesses clear the read register instead of touching RAM.
  dmem_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .wr_en (commit && c_we && c_ok),
    .rd_en (commit && !c_we && c_ok),
    .rd_clr(commit && !c_ok),
    .idx   (c_idx),
    .be    (c_sel),
    .wdata (c_wdata),
    .rdata (rdata)
  );

  assign stall = ((state_q == S_IDLE) && req && !flush)
              || ((state_q == S_BUSY) && !flush);
  assign err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the CPU's M-stage data interface: address, write data, 4-bit byte select, write strobe in; read data and stall out.
- Models a word-organised RAM with a configurable number of wait states.
- Holds the pipeline through its stall output until the access completes.
- Sits in the SoC top beside the CPU core; one instance per data port.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W 32-bit words.
- BASE, 32'h0000_0000, byte address of word 0; addresses outside [BASE, BASE+4*2**ADDR_W) are out of range.
- LATENCY, 2, number of stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- req  in  1  access request; held stable by the CPU while stall=1.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  32  byte address; bits [1:0] ignored, word index = (addr-BASE)[ADDR_W+1:2].
- sel  in  4  byte enables; bit i enables wdata[8i+7:8i].
- wdata  in  32  write data, already lane-aligned.
- flush  in  1  M-stage flush; aborts a pending access.
- rdata  out  32  read data, valid in the DONE cycle, held until the next completion.
- stall  out  1  1 = responder busy; CPU must freeze M and earlier stages.
- err  out  1  one-cycle pulse in DONE when the access was out of range.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, stall=0, err=0, rdata=0. RAM contents are not cleared.
- States: IDLE, BUSY, DONE. 4-bit down-counter cnt.
- stall is combinational: stall = (state==IDLE & req & ~flush) | (state==BUSY & ~flush).
- IDLE:
  - req=1 & flush=0: latch we/addr/sel/wdata into a request register; cnt <= LATENCY-1.
  - If LATENCY==1, commit the access on this edge -> DONE; otherwise -> BUSY.
  - req=0: stay in IDLE.
- BUSY:
  - cnt decrements each cycle.
  - When cnt==1, commit on this edge -> DONE.
  - Net effect: stall is high for exactly LATENCY consecutive cycles starting with the request cycle.
- Commit:
  - Write: for each i with sel[i]=1, mem[idx].byte[i] <= wdata.byte[i]. Bytes with sel[i]=0 are untouched; sel=0 writes nothing.
  - Read: rdata <= mem[idx] (full word; lane extraction is the CPU's job).
  - Out of range: no write; rdata <= 0; err <= 1 for the DONE cycle.
  - Writes leave rdata unchanged.
- DONE:
  - stall=0, so the CPU advances at the end of this cycle; err is valid this cycle only.
  - Next state IDLE unconditionally. A req seen in the following IDLE cycle is a new access, so back-to-back accesses cost LATENCY+1 cycles each.
- flush:
  - In BUSY: abort. No commit, next state IDLE, stall=0 that cycle, rdata unchanged.
  - In IDLE with req: request ignored.
  - In DONE: no effect; the access is already committed.
- Read after write to the same word returns the new data (commit precedes the next request).
- The request register decouples from CPU inputs; input changes during BUSY are ignored.

Decomposition:
- Shared package (e.g. mem_pkg):
  - State encodings S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2.
  - Constant for the maximum LATENCY (15).
  - Range-check function.
- One natural sub-module, dmem_bank: a single-port 2**ADDR_W x 32 array with per-byte write enable and synchronous read. dmem_responder holds the FSM, counter, request register and range check.

Test Plan:
- Reset mid-BUSY: assert rst during BUSY -> stall, err and rdata drop to 0 immediately; a subsequent read of a previously written word returns the old contents.
- LATENCY=2, write 32'hDEADBEEF, sel=4'hF, addr=BASE+8; then read the same address:
  - Write: stall=1 for 2 cycles, then 1 cycle DONE.
  - Read: rdata=32'hDEADBEEF in its DONE cycle.
- Partial write:
  - After the word holds 32'h11223344, write wdata=32'hAABBCCDD, sel=4'b0110.
  - Read back -> 32'h11BBCC44.
  - sel=0 write -> word unchanged.
- Flush in BUSY: LATENCY=3 write 32'h0 with flush asserted in the 2nd stall cycle -> stall=0 that cycle; later read returns the prior value.
- Out-of-range: read addr=BASE+4*2**ADDR_W -> err=1 for exactly one cycle, rdata=0; an out-of-range write leaves all words unchanged.
- LATENCY=1, back-to-back reads of words 0 and 1 -> each shows 1 stall cycle followed by DONE, 2 cycles per access, correct data each time.
